// File: rtl/sensor_pkg.sv
// Shared types and widths for the two-channel beam-sensor conditioner.
package sensor_pkg;

   typedef enum logic {ST_STABLE, ST_CONFIRM} deb_state_t;

   localparam int SENSOR_W = 2;
   localparam int GLITCH_W = 8;

endpackage

// File: rtl/debounce_chan.sv
// One sensor channel: 2-flop synchroniser followed by a confirm-counter debounce FSM.
module debounce_chan
   import sensor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic btn,
   output logic btn_chg,
   output logic reject
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   deb_state_t       state;
   deb_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             btn_nxt;
   logic             chg_nxt;

   // Synchroniser and FSM registers share the asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         state   <= ST_STABLE;
         cnt     <= '0;
         btn     <= 1'b0;
         btn_chg <= 1'b0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         btn     <= btn_nxt;
         btn_chg <= chg_nxt;
      end
   end

   // cnt counts consecutive mismatching cycles; the Dth one commits the new level
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      btn_nxt   = btn;
      chg_nxt   = 1'b0;
      reject    = 1'b0;
      case (state)
         ST_STABLE: begin
            if (sync2 != btn) begin
               state_nxt = ST_CONFIRM;
               cnt_nxt   = CNT_ONE;
            end else begin
               cnt_nxt = '0;
            end
         end
         ST_CONFIRM: begin
            if (sync2 == btn) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
               reject    = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
               btn_nxt   = sync2;
               chg_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/sensor_debounce.sv
// Two-channel sensor input conditioner with a saturating count of rejected glitches.
module sensor_debounce
   import sensor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SENSOR_W-1:0] raw_btn,
   output logic [SENSOR_W-1:0] btn,
   output logic [SENSOR_W-1:0] btn_chg,
   output logic [GLITCH_W-1:0] glitch_count
);

   logic [SENSOR_W-1:0] reject;
   logic [1:0]          rej_sum;

   function automatic logic [GLITCH_W-1:0] sat_add(input logic [GLITCH_W-1:0] acc,
                                                   input logic [1:0]          inc);
      logic [GLITCH_W:0] sum;
      sum = {1'b0, acc} + {{(GLITCH_W-1){1'b0}}, inc};
      return sum[GLITCH_W] ? {GLITCH_W{1'b1}} : sum[GLITCH_W-1:0];
   endfunction

   for (genvar i = 0; i < SENSOR_W; i++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .raw     (raw_btn[i]),
         .btn     (btn[i]),
         .btn_chg (btn_chg[i]),
         .reject  (reject[i])
      );
   end

   // Both channels may reject on the same cycle, so add 0..2 per edge
   assign rej_sum = {1'b0, reject[0]} + {1'b0, reject[1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         glitch_count <= '0;
      end else begin
         glitch_count <= sat_add(glitch_count, rej_sum);
      end
   end

endmodule

// File: tb/tb_sensor_debounce.sv
// Randomised and directed bench for sensor_debounce against a run-length reference model.
module tb_sensor_debounce;

   localparam int DEB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] raw_btn = 2'b00;
   logic [1:0] btn;
   logic [1:0] btn_chg;
   logic [7:0] glitch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk          (clk),
      .reset        (reset),
      .raw_btn      (raw_btn),
      .btn          (btn),
      .btn_chg      (btn_chg),
      .glitch_count (glitch_count)
   );

   // Reference: a level is adopted after DEB consecutive mismatching synchronised
   // samples; a mismatch run that ends early is one glitch.
   logic [1:0] h1 = 2'b00;
   logic [1:0] h2 = 2'b00;
   logic [1:0] mbtn = 2'b00;
   logic [1:0] mchg = 2'b00;
   int         run [2] = '{0, 0};
   int         mglitch = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         h1 = 2'b00; h2 = 2'b00; mbtn = 2'b00; mchg = 2'b00;
         run[0] = 0; run[1] = 0; mglitch = 0;
      end else begin
         int strobes;
         strobes = 0;
         mchg = 2'b00;
         for (int c = 0; c < 2; c++) begin
            if (h2[c] != mbtn[c]) begin
               run[c] = run[c] + 1;
               if (run[c] == DEB) begin
                  mbtn[c] = h2[c];
                  mchg[c] = 1'b1;
                  run[c]  = 0;
               end
            end else begin
               if (run[c] > 0) strobes = strobes + 1;
               run[c] = 0;
            end
         end
         mglitch = (mglitch + strobes > 255) ? 255 : mglitch + strobes;
         h2 = h1;
         h1 = raw_btn;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_btn(input logic [1:0] mask, input logic [1:0] val,
                           output int edges, output int mixed);
      edges = -1;
      mixed = 0;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk);
         #2;
         if (btn == 2'b01 || btn == 2'b10) mixed++;
         if ((btn & mask) == val) begin
            edges = e;
            break;
         end
      end
   endtask

   task automatic glitch_pulse(input logic [1:0] bits);
      raw_btn = bits;
      step(1);
      raw_btn = 2'b00;
      step(3);
   endtask

   initial begin
      int e;
      int mixed;
      int chg_seen;
      logic [1:0] seq_in  [4];
      logic [1:0] seq_out [4];

      fork
         forever begin
            @(negedge clk);
            chk("model_btn", int'(btn), int'(mbtn));
            chk("model_btn_chg", int'(btn_chg), int'(mchg));
            chk("model_glitch", int'(glitch_count), mglitch);
         end
      join_none

      // Scenario 1: reset with both lines high, then qualify them
      reset = 1'b0;
      raw_btn = 2'b11;
      step(4);
      chk("rst_btn", int'(btn), 0);
      chk("rst_glitch", int'(glitch_count), 0);
      reset = 1'b1;
      wait_btn(2'b11, 2'b11, e, mixed);
      chk("t1_latency", e, 18);
      chk("t1_chg", int'(btn_chg), 3);
      step(1);
      chk("t1_chg_once", int'(btn_chg), 0);

      // Scenario 2: short pulse is rejected, 16-cycle pulse passes
      raw_btn = 2'b00;
      step(40);
      chk("t2_idle", int'(btn), 0);
      chg_seen = 0;
      for (int i = 0; i < 35; i++) begin
         raw_btn = (i < 5) ? 2'b01 : 2'b00;
         step(1);
         if (btn_chg != 2'b00) chg_seen++;
      end
      chk("t2_short_chg", chg_seen, 0);
      chk("t2_short_btn", int'(btn), 0);
      chk("t2_short_glitch", int'(glitch_count), 1);
      e = -1;
      raw_btn = 2'b01;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #2;
         if (i == 16) raw_btn = 2'b00;
         if (btn[0] && e < 0) e = i;
      end
      chk("t2_pass_latency", e, 18);
      step(30);
      chk("t2_pass_glitch", int'(glitch_count), 1);

      // Scenario 3: entry then exit sequence, each step 100 cycles
      seq_in  = '{2'b01, 2'b11, 2'b10, 2'b00};
      seq_out = '{2'b10, 2'b11, 2'b01, 2'b00};
      for (int k = 0; k < 4; k++) begin
         raw_btn = seq_in[k];
         wait_btn(2'b11, seq_in[k], e, mixed);
         chk("t3_entry_latency", e, 18);
         step(82);
      end
      for (int k = 0; k < 4; k++) begin
         raw_btn = seq_out[k];
         wait_btn(2'b11, seq_out[k], e, mixed);
         chk("t3_exit_latency", e, 18);
         step(82);
      end
      chk("t3_glitch", int'(glitch_count), 1);

      // Scenario 4: saturation of the glitch counter
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(3);
      for (int k = 0; k < 254; k++) glitch_pulse(2'b10);
      step(4);
      chk("t4_254", int'(glitch_count), 254);
      glitch_pulse(2'b11);
      step(2);
      chk("t4_sat_dual", int'(glitch_count), 255);
      for (int k = 0; k < 10; k++) glitch_pulse(2'b10);
      step(2);
      chk("t4_sat_hold", int'(glitch_count), 255);

      // Scenario 5: asynchronous reset during a confirmation
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      raw_btn = 2'b10;
      wait_btn(2'b11, 2'b10, e, mixed);
      chk("t5_pre_latency", e, 18);
      step(5);
      for (int k = 0; k < 3; k++) glitch_pulse(2'b01);
      step(2);
      chk("t5_pre_glitch", int'(glitch_count), 3);
      raw_btn = 2'b11;
      step(12);
      reset = 1'b0;
      #1;
      chk("t5_async_btn", int'(btn), 0);
      chk("t5_async_chg", int'(btn_chg), 0);
      chk("t5_async_glitch", int'(glitch_count), 0);
      step(3);
      reset = 1'b1;
      wait_btn(2'b11, 2'b11, e, mixed);
      chk("t5_requalify", e, 18);

      // Scenario 6: both channels change on the same edge
      raw_btn = 2'b00;
      step(40);
      chk("t6_idle", int'(btn), 0);
      raw_btn = 2'b11;
      wait_btn(2'b11, 2'b11, e, mixed);
      chk("t6_latency", e, 18);
      chk("t6_no_mixed", mixed, 0);
      chk("t6_chg", int'(btn_chg), 3);
      step(1);
      chk("t6_chg_once", int'(btn_chg), 0);

      // Random segments with occasional resets, checked by the model each cycle
      for (int s = 0; s < 300; s++) begin
         raw_btn = 2'($urandom_range(0, 3));
         step($urandom_range(1, 24));
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b0;
            step(2);
            reset = 1'b1;
         end
      end
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
